// File: rtl/pixel_read_dma.sv
// Register-programmed DMA that reads a run of RGB565 pixels over a pipelined
// read master and replays them, in address order, on a ready/valid stream.
module pixel_read_dma #(
  parameter int FIFO_DEPTH   = 8,
  parameter int MAX_PIXELS_W = 17
) (
  input  logic        csi_clockreset_clk,
  input  logic        csi_clockreset_reset,
  input  logic        avs_slave_chipselect,
  input  logic        avs_slave_read,
  input  logic        avs_slave_write,
  input  logic [2:0]  avs_slave_address,
  input  logic [31:0] avs_slave_writedata,
  output logic [31:0] avs_slave_readdata,
  output logic [31:0] avm_master_address,
  output logic        avm_master_read,
  output logic [1:0]  avm_master_byteenable,
  input  logic        avm_master_waitrequest,
  input  logic        avm_master_readdatavalid,
  input  logic [15:0] avm_master_readdata,
  output logic [15:0] aso_out_data,
  output logic        aso_out_valid,
  input  logic        aso_out_ready,
  output logic        aso_out_startofpacket,
  output logic        aso_out_endofpacket
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [MAX_PIXELS_W-1:0] PIX_ONE   = 1;
  localparam logic [PTR_W:0]          OUT_ONE   = 1;
  localparam logic [PTR_W+1:0]        DEPTH_L   = FIFO_DEPTH;
  localparam logic [31:0]             ADDR_STEP = 32'd2;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                  state_reg, state_next;
  logic                    done_reg, done_next;
  logic [31:0]             base_reg;
  logic [31:0]             addr_reg, addr_next;
  logic [MAX_PIXELS_W-1:0] count_reg;
  logic [MAX_PIXELS_W-1:0] issued_reg, issued_next;
  logic [MAX_PIXELS_W-1:0] emitted_reg, emitted_next;
  logic [PTR_W:0]          outstanding_reg, outstanding_next;
  logic [PTR_W:0]          wr_ptr_reg, rd_ptr_reg;
  logic [15:0]             fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]          fifo_used;
  logic [PTR_W+1:0]        fifo_commit;
  logic                    fifo_empty;
  logic                    busy, reg_wr, go, accept, push, pop;
  logic                    read_strobe_unused;

  assign read_strobe_unused = avs_slave_read;

  assign busy   = (state_reg != IDLE);
  assign reg_wr = avs_slave_chipselect & avs_slave_write;
  assign go     = reg_wr & (avs_slave_address == 3'd0) & avs_slave_writedata[0];

  // Space already promised = pixels buffered plus pixels still in flight.
  assign fifo_used   = wr_ptr_reg - rd_ptr_reg;
  assign fifo_empty  = (fifo_used == '0);
  assign fifo_commit = {1'b0, fifo_used} + {1'b0, outstanding_reg};

  assign avm_master_read = (state_reg == FETCH) && (issued_reg < count_reg) &&
                           (fifo_commit < DEPTH_L);
  assign avm_master_address    = addr_reg;
  assign avm_master_byteenable = 2'b11;

  assign accept = avm_master_read & ~avm_master_waitrequest;
  assign push   = avm_master_readdatavalid & (outstanding_reg != '0);
  assign pop    = ~fifo_empty & aso_out_ready;

  assign aso_out_valid         = ~fifo_empty;
  assign aso_out_data          = fifo_mem[rd_ptr_reg[PTR_W-1:0]];
  assign aso_out_startofpacket = ~fifo_empty & (emitted_reg == '0);
  assign aso_out_endofpacket   = ~fifo_empty & (emitted_reg == count_reg - PIX_ONE);

  always_comb begin
    avs_slave_readdata = 32'd0;
    case (avs_slave_address)
      3'd0:    avs_slave_readdata = {30'd0, done_reg, busy};
      3'd1:    avs_slave_readdata = base_reg;
      3'd2:    avs_slave_readdata = 32'(count_reg);
      3'd3:    avs_slave_readdata = 32'(emitted_reg);
      default: avs_slave_readdata = 32'd0;
    endcase
  end

  always_comb begin
    state_next       = state_reg;
    done_next        = done_reg;
    addr_next        = addr_reg;
    issued_next      = issued_reg;
    emitted_next     = emitted_reg;
    outstanding_next = outstanding_reg;
    if (pop) emitted_next = emitted_reg + PIX_ONE;
    case ({accept, push})
      2'b10:   outstanding_next = outstanding_reg + OUT_ONE;
      2'b01:   outstanding_next = outstanding_reg - OUT_ONE;
      default: outstanding_next = outstanding_reg;
    endcase
    case (state_reg)
      IDLE: begin
        if (go) begin
          if (count_reg != '0) begin
            state_next   = FETCH;
            done_next    = 1'b0;
            addr_next    = base_reg;
            issued_next  = '0;
            emitted_next = '0;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      FETCH: begin
        if (accept) begin
          addr_next   = addr_reg + ADDR_STEP;
          issued_next = issued_reg + PIX_ONE;
          if (issued_next == count_reg) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (emitted_reg == count_reg) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
    if (csi_clockreset_reset) begin
      state_reg       <= IDLE;
      done_reg        <= 1'b0;
      addr_reg        <= 32'd0;
      issued_reg      <= '0;
      emitted_reg     <= '0;
      outstanding_reg <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      state_reg       <= state_next;
      done_reg        <= done_next;
      addr_reg        <= addr_next;
      issued_reg      <= issued_next;
      emitted_reg     <= emitted_next;
      outstanding_reg <= outstanding_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + OUT_ONE;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + OUT_ONE;
    end
  end

  // Base and count are frozen for the duration of a transfer.
  always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
    if (csi_clockreset_reset) begin
      base_reg  <= 32'd0;
      count_reg <= '0;
    end else if (reg_wr && !busy) begin
      if (avs_slave_address == 3'd1) base_reg  <= avs_slave_writedata;
      if (avs_slave_address == 3'd2) count_reg <= avs_slave_writedata[MAX_PIXELS_W-1:0];
    end
  end

  always_ff @(posedge csi_clockreset_clk) begin
    if (push) fifo_mem[wr_ptr_reg[PTR_W-1:0]] <= avm_master_readdata;
  end

endmodule

// File: tb/tb_pixel_read_dma.sv
// Scoreboard bench for pixel_read_dma: memory model answers reads one cycle
// after acceptance, a monitor pops expected pixels on every stream handshake.
`timescale 1ns/1ps
module tb_pixel_read_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs, rd, wr;
  logic [2:0]  addr;
  logic [31:0] wdata, rdata_reg;
  logic [31:0] m_address;
  logic        m_read;
  logic [1:0]  m_be;
  logic        m_wait, m_rdv;
  logic [15:0] m_rdata;
  logic [15:0] out_data;
  logic        out_valid, out_ready, out_sop, out_eop;

  always #5 clk = ~clk;

  pixel_read_dma #(.FIFO_DEPTH(8), .MAX_PIXELS_W(17)) dut (
    .csi_clockreset_clk      (clk),
    .csi_clockreset_reset    (rst),
    .avs_slave_chipselect    (cs),
    .avs_slave_read          (rd),
    .avs_slave_write         (wr),
    .avs_slave_address       (addr),
    .avs_slave_writedata     (wdata),
    .avs_slave_readdata      (rdata_reg),
    .avm_master_address      (m_address),
    .avm_master_read         (m_read),
    .avm_master_byteenable   (m_be),
    .avm_master_waitrequest  (m_wait),
    .avm_master_readdatavalid(m_rdv),
    .avm_master_readdata     (m_rdata),
    .aso_out_data            (out_data),
    .aso_out_valid           (out_valid),
    .aso_out_ready           (out_ready),
    .aso_out_startofpacket   (out_sop),
    .aso_out_endofpacket     (out_eop)
  );

  typedef struct packed {
    logic [15:0] data;
    logic        sop;
    logic        eop;
  } pix_t;

  int          checks = 0;
  int          errors = 0;
  int          pops = 0;
  pix_t        exp_q[$];
  logic [31:0] resp_q[$];
  logic [31:0] exp_base = 32'd0;
  int          acc_cnt = 0;
  int          reads_seen = 0;
  int          stall_at = -1;
  int          stall_len = 0;
  int          stall_done = 0;
  logic [31:0] stall_addr = 32'd0;
  int          late_pulses = 0;

  function automatic logic [15:0] pixel_of(input logic [31:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Memory: one response per accepted read, returned the following cycle.
  initial begin
    m_wait = 1'b0; m_rdv = 1'b0; m_rdata = 16'd0;
    forever begin
      @(negedge clk);
      m_rdv = 1'b0;
      if (late_pulses > 0) begin
        m_rdv = 1'b1; m_rdata = 16'hDEAD; late_pulses--;
      end else if (resp_q.size() > 0) begin
        m_rdv = 1'b1; m_rdata = pixel_of(resp_q.pop_front());
      end
      m_wait = 1'b0;
      if (m_read) begin
        reads_seen++;
        check("byteenable", 32'(m_be), 32'h3);
        if (acc_cnt == stall_at && stall_done < stall_len) begin
          if (stall_done == 0) stall_addr = m_address;
          else check("stall_addr_stable", m_address, stall_addr);
          m_wait = 1'b1;
          stall_done++;
        end else begin
          check("read_addr", m_address, exp_base + 32'(2 * acc_cnt));
          acc_cnt++;
          resp_q.push_back(m_address);
        end
      end
    end
  end

  // Monitor: every stream handshake must match the head of the scoreboard.
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pixel actual=%h required=none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("pix_data", 32'(out_data), 32'(e.data));
          check("pix_sop",  32'(out_sop),  32'(e.sop));
          check("pix_eop",  32'(out_eop),  32'(e.eop));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "simulation timeout");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    #1;
    d = rdata_reg;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic start(input logic [31:0] base, input int count);
    exp_base = base;
    acc_cnt  = 0;
    for (int i = 0; i < count; i++)
      exp_q.push_back({pixel_of(base + 32'(2 * i)), i == 0, i == count - 1});
    reg_write(3'd1, base);
    reg_write(3'd2, 32'(count));
    reg_write(3'd0, 32'd1);
  endtask

  task automatic wait_done(input string name, input int limit);
    logic [31:0] s;
    s = 32'd0;
    for (int k = 0; k < limit; k++) begin
      reg_read(3'd0, s);
      if (s[1]) break;
      tick();
    end
    check(name, 32'(s[1:0]), 32'h2);
  endtask

  initial begin
    logic [31:0] v;
    int          pops0;
    rst = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 3'd0; wdata = 32'd0;
    out_ready = 1'b0;
    tick(3);
    check("rst_read", 32'(m_read), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_address", m_address, 32'h0);
    check("rst_byteenable", 32'(m_be), 32'h3);
    rst = 1'b0;
    tick();
    for (int a = 0; a < 4; a++) begin
      reg_read(3'(a), v);
      check("rst_reg", v, 32'h0);
    end

    // Go with a zero count: Done next cycle, never Busy, no reads.
    tick();
    reads_seen = 0;
    reg_write(3'd2, 32'd0);
    reg_write(3'd0, 32'd1);
    for (int k = 0; k < 5; k++) begin
      reg_read(3'd0, v);
      check("zero_count_status", v, 32'h2);
      tick();
    end
    check("zero_count_reads", 32'(reads_seen), 32'h0);

    // Basic four-pixel transfer, zero-wait memory, sink always ready.
    out_ready = 1'b1;
    start(32'h0800_0000, 4);
    reg_read(3'd0, v);
    check("busy_after_go", v, 32'h1);
    wait_done("done_basic", 300);
    reg_read(3'd3, v);
    check("emitted_basic", v, 32'd4);
    check("drained_basic", 32'(exp_q.size()), 32'h0);
    check("accepted_basic", 32'(acc_cnt), 32'd4);

    // Back-pressure: only FIFO_DEPTH reads may be in the air or buffered.
    tick();
    out_ready = 1'b0;
    start(32'h0900_0000, 20);
    tick(30);
    check("bp_accepted", 32'(acc_cnt), 32'd8);
    check("bp_read_low", 32'(m_read), 32'h0);
    out_ready = 1'b1;
    wait_done("done_bp", 500);
    reg_read(3'd3, v);
    check("emitted_bp", v, 32'd20);
    check("drained_bp", 32'(exp_q.size()), 32'h0);
    check("accepted_bp", 32'(acc_cnt), 32'd20);

    // Wait states on the second read.
    tick();
    stall_at = 1; stall_len = 3; stall_done = 0;
    start(32'h0800_0000, 4);
    wait_done("done_stall", 300);
    check("stall_cycles", 32'(stall_done), 32'd3);
    check("drained_stall", 32'(exp_q.size()), 32'h0);
    check("accepted_stall", 32'(acc_cnt), 32'd4);
    stall_at = -1;

    // Go and register writes while Busy are ignored.
    tick();
    out_ready = 1'b0;
    start(32'h0A00_0000, 6);
    reg_write(3'd0, 32'd1);
    reg_write(3'd2, 32'd2);
    reg_write(3'd1, 32'h0B00_0000);
    reg_read(3'd2, v);
    check("count_locked", v, 32'd6);
    reg_read(3'd1, v);
    check("base_locked", v, 32'h0A00_0000);
    out_ready = 1'b1;
    wait_done("done_locked", 300);
    reg_read(3'd3, v);
    check("emitted_locked", v, 32'd6);
    check("drained_locked", 32'(exp_q.size()), 32'h0);

    // Reset after three of ten pixels, then late responses.
    tick();
    out_ready = 1'b0;
    start(32'h0C00_0000, 10);
    tick(20);
    pops0 = pops;
    out_ready = 1'b1;
    tick(3);
    out_ready = 1'b0;
    check("pre_reset_pops", 32'(pops - pops0), 32'd3);
    reg_read(3'd3, v);
    check("pre_reset_emitted", v, 32'd3);
    rst = 1'b1;
    #1;
    check("abort_valid", 32'(out_valid), 32'h0);
    check("abort_sop", 32'(out_sop), 32'h0);
    check("abort_eop", 32'(out_eop), 32'h0);
    check("abort_read", 32'(m_read), 32'h0);
    check("abort_address", m_address, 32'h0);
    reg_read(3'd0, v);
    check("abort_status", v, 32'h0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    late_pulses = 2;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("late_valid", 32'(out_valid), 32'h0);
    end
    reg_read(3'd3, v);
    check("late_emitted", v, 32'h0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
